// File: rtl/mmio_uart_tx.sv
// Bus-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR/CTRL window, byte FIFO, LSB-first serializer.
// Write lands in FIFO at edge N, pop/start bit at N+1, frame 10*DIVISOR clocks; full-FIFO writes drop and set overflow. Optional IRQ: MMIO_UART_IRQ_EN.
module mmio_uart_tx #(
  parameter logic [7:0]  BASE_ADDR  = 8'hF0,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] CLK_DIV    = 16'd16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iCE,
  input  logic        iRD,
  input  logic        iWR,
  input  logic [7:0]  iADDR,
  input  logic [31:0] iDATA,
  output logic [31:0] oDATA,
  output logic        oTX,
  output logic        oIRQ
);

  localparam int PW = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [15:0]   bit_cnt, bit_cnt_nxt;
  logic          tx;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          overflow;
  logic [15:0]   divisor;
  logic [15:0]   div_eff;
  logic          irq_en;

  logic [7:0]    off;
  logic          sel, wr_en, push, push_ok, pop;
  logic          full, empty, busy, bit_end;
  logic [7:0]    head;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign unused_bits = ^iDATA[31:16];

  // Subtracting the base keeps the window check free of carry-out at the top of the map.
  assign off     = iADDR - BASE_ADDR;
  assign sel     = iCE && (off < 8'd4);
  assign wr_en   = sel && iWR;
  assign push    = wr_en && (off[1:0] == 2'd0);
  assign full    = (count == DEPTH_C);
  assign empty   = (count == 5'd0);
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr];
  assign busy    = (state != IDLE);
  assign bit_end = (bit_cnt == 16'd1);
  assign div_eff = (divisor == 16'd0) ? 16'd1 : divisor;

  always_ff @(posedge iCLK) begin
    if (push_ok) mem[wr_ptr] <= iDATA[7:0];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
      divisor  <= CLK_DIV;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (push && !push_ok)
        overflow <= 1'b1;
      else if (wr_en && (off[1:0] == 2'd1) && iDATA[3])
        overflow <= 1'b0;
      if (wr_en && (off[1:0] == 2'd2)) divisor <= iDATA[15:0];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      shift   <= 8'h00;
      bit_idx <= 3'd0;
      bit_cnt <= 16'd1;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_idx <= bit_idx_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Each bit reloads the counter from the live divisor, so divisor writes apply at the next bit boundary.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_idx_nxt = bit_idx;
    bit_cnt_nxt = bit_cnt;
    pop         = 1'b0;
    tx          = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          shift_nxt   = head;
          bit_cnt_nxt = div_eff;
          state_nxt   = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          bit_idx_nxt = 3'd0;
          bit_cnt_nxt = div_eff;
          state_nxt   = DATA;
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      DATA: begin
        tx = shift[0];
        if (bit_end) begin
          bit_cnt_nxt = div_eff;
          shift_nxt   = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop         = 1'b1;
            shift_nxt   = head;
            bit_cnt_nxt = div_eff;
            state_nxt   = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign oTX = tx;

`ifdef MMIO_UART_IRQ_EN
  logic irq_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && (off[1:0] == 2'd3)) irq_en <= iDATA[0];
      irq_q <= irq_en && empty && (state == IDLE);
    end
  end

  assign oIRQ = irq_q;
`else
  assign irq_en = 1'b0;
  assign oIRQ   = 1'b0;
`endif

  always_comb begin
    rdata = 32'h0;
    if (sel && iRD) begin
      case (off[1:0])
        2'd1:    rdata = {23'b0, count, overflow, empty, full, busy};
        2'd2:    rdata = {16'b0, divisor};
        2'd3:    rdata = {31'b0, irq_en};
        default: rdata = 32'h0;
      endcase
    end
  end

  assign oDATA = rdata;

endmodule
